// File: rtl/nios_system_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
interface nios_system_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_led_pio.sv
// Output PIO: data register with atomic set/clear and a one-shot pulse engine.
module nios_system_led_pio #(
    parameter int unsigned      WIDTH           = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter logic [15:0]      PULSE_LEN_RESET = 16'd1000
) (
    input  logic                  clk,
    input  logic                  reset,
    nios_system_led_pio_if.slave  bus,
    output logic [WIDTH-1:0]      out_port
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      pulse_len_q, pulse_len_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic             busy;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign busy      = (count_q != 16'd0);
    assign unused_wd = ^bus.writedata;

    // Next-state for output, pulse engine and PULSE_LEN; CPU writes are applied after expiry.
    always_comb begin
        out_d        = out_q;
        pulse_mask_d = pulse_mask_q;
        count_d      = count_q;
        pulse_len_d  = pulse_len_q;

        if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
        end
        if (count_q == 16'd1) begin
            out_d        = out_d & ~pulse_mask_q;
            pulse_mask_d = '0;
        end

        if (wr) begin
            case (bus.address)
                3'd0: out_d       = wd;
                3'd1: pulse_len_d = bus.writedata[15:0];
                3'd4: out_d       = out_d | wd;
                3'd5: out_d       = out_d & ~wd;
                3'd6: begin
                    // On the expiry cycle pulse_mask_d is already cleared, so only the new mask survives.
                    if ((pulse_len_q != 16'd0) && (wd != '0)) begin
                        out_d        = out_d | wd;
                        pulse_mask_d = pulse_mask_d | wd;
                        count_d      = pulse_len_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read mux, sampled every clock independent of chipselect.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            3'd0:    readdata_d = 32'(out_q);
            3'd1:    readdata_d = 32'(pulse_len_q);
            3'd7:    readdata_d = (32'(pulse_mask_q) << 8) | 32'(busy);
            default: readdata_d = '0;
        endcase
    end

    // State registers with asynchronous reset; reset aborts any running pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= RESET_VALUE;
            pulse_mask_q <= '0;
            count_q      <= '0;
            pulse_len_q  <= PULSE_LEN_RESET;
            readdata_q   <= '0;
        end else begin
            out_q        <= out_d;
            pulse_mask_q <= pulse_mask_d;
            count_q      <= count_d;
            pulse_len_q  <= pulse_len_d;
            readdata_q   <= readdata_d;
        end
    end

    assign out_port     = out_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_nios_system_led_pio.sv
// Directed self-checking bench for the LED output PIO.
module tb_nios_system_led_pio;

    logic       clk;
    logic       reset;
    logic [7:0] out_port;
    int         tests_run;
    int         tests_failed;

    nios_system_led_pio_if bus ();

    nios_system_led_pio #(
        .WIDTH           (8),
        .RESET_VALUE     (8'hA5),
        .PULSE_LEN_RESET (16'd1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write cycle; returns 1ns after the capturing edge.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Presents an address for one clock; readdata is valid on return.
    task automatic bus_read(input logic [2:0] addr);
        bus.address = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        tests_run++;
        if (out_port !== 8'hA5) begin
            tests_failed++;
            $display("FAIL reset_out: got %h expected %h", out_port, 8'hA5);
        end
        tests_run++;
        if (bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
        end
        bus.address = 3'd1;
        reset = 1'b0;
        bus_read(3'd1);
        tests_run++;
        if (bus.readdata !== 32'd1000) begin
            tests_failed++;
            $display("FAIL reset_pulse_len: got %0d expected %0d", bus.readdata, 1000);
        end
    endtask

    task automatic test_data_set_clear();
        bus_write(3'd0, 32'hFFFF_FF3C);
        tests_run++;
        if (out_port !== 8'h3C) begin
            tests_failed++;
            $display("FAIL data_write: got %h expected %h", out_port, 8'h3C);
        end
        bus_write(3'd4, 32'h0000_0081);
        tests_run++;
        if (out_port !== 8'hBD) begin
            tests_failed++;
            $display("FAIL outset: got %h expected %h", out_port, 8'hBD);
        end
        bus_write(3'd5, 32'h0000_000C);
        tests_run++;
        if (out_port !== 8'hB1) begin
            tests_failed++;
            $display("FAIL outclear: got %h expected %h", out_port, 8'hB1);
        end
        bus_read(3'd0);
        tests_run++;
        if (bus.readdata !== 32'h0000_00B1) begin
            tests_failed++;
            $display("FAIL data_read: got %h expected %h", bus.readdata, 32'h0000_00B1);
        end
    endtask

    task automatic test_pulse();
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h01);            // edge N
        bus.address = 3'd7;
        tests_run++;
        if (out_port !== 8'h01) begin
            tests_failed++;
            $display("FAIL pulse_after_n: got %h expected %h", out_port, 8'h01);
        end
        @(posedge clk); #1;                 // N+1
        tests_run++;
        if (bus.readdata !== 32'h0000_0101) begin
            tests_failed++;
            $display("FAIL pulse_status_busy: got %h expected %h", bus.readdata, 32'h0000_0101);
        end
        @(posedge clk); #1;                 // N+2
        tests_run++;
        if (out_port !== 8'h01) begin
            tests_failed++;
            $display("FAIL pulse_after_n2: got %h expected %h", out_port, 8'h01);
        end
        @(posedge clk); #1;                 // N+3
        tests_run++;
        if (out_port !== 8'h00) begin
            tests_failed++;
            $display("FAIL pulse_after_n3: got %h expected %h", out_port, 8'h00);
        end
        @(posedge clk); #1;                 // N+4
        tests_run++;
        if (bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL pulse_status_idle: got %h expected %h", bus.readdata, 32'h0);
        end
    endtask

    task automatic test_retrigger();
        bus_write(3'd1, 32'd4);
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h01);            // edge N
        @(posedge clk); #1;                 // N+1
        bus_write(3'd6, 32'h02);            // edge N+2
        for (int k = 2; k <= 5; k++) begin
            tests_run++;
            if (out_port !== 8'h03) begin
                tests_failed++;
                $display("FAIL retrigger_hold_n%0d: got %h expected %h", k, out_port, 8'h03);
            end
            @(posedge clk); #1;
        end
        tests_run++;                        // N+6
        if (out_port !== 8'h00) begin
            tests_failed++;
            $display("FAIL retrigger_end: got %h expected %h", out_port, 8'h00);
        end
    endtask

    task automatic test_expiry_priority();
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h01);            // edge N, count=2
        @(posedge clk); #1;                 // N+1, count=1
        bus_write(3'd0, 32'hFF);            // edge N+2 is the expiry edge
        tests_run++;
        if (out_port !== 8'hFF) begin
            tests_failed++;
            $display("FAIL expiry_data_wins: got %h expected %h", out_port, 8'hFF);
        end
        bus_read(3'd7);
        bus_read(3'd7);
        tests_run++;
        if (bus.readdata !== 32'h0 || out_port !== 8'hFF) begin
            tests_failed++;
            $display("FAIL expiry_after: got status %h out %h expected %h / %h",
                     bus.readdata, out_port, 32'h0, 8'hFF);
        end

        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h01);            // edge N, count=3
        @(posedge clk); #1;                 // N+1
        @(posedge clk); #1;                 // N+2, count=1
        bus_write(3'd6, 32'h02);            // edge N+3: fresh pulse
        tests_run++;
        if (out_port !== 8'h02) begin
            tests_failed++;
            $display("FAIL expiry_fresh_pulse: got %h expected %h", out_port, 8'h02);
        end
        bus_read(3'd7);
        tests_run++;
        if (bus.readdata !== 32'h0000_0201) begin
            tests_failed++;
            $display("FAIL expiry_fresh_status: got %h expected %h", bus.readdata, 32'h0000_0201);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (out_port !== 8'h00) begin
            tests_failed++;
            $display("FAIL expiry_fresh_end: got %h expected %h", out_port, 8'h00);
        end
    endtask

    task automatic test_pulse_noop();
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'h5A);
        bus_write(3'd6, 32'hFF);
        tests_run++;
        if (out_port !== 8'h5A) begin
            tests_failed++;
            $display("FAIL len_zero_out: got %h expected %h", out_port, 8'h5A);
        end
        bus_read(3'd7);
        tests_run++;
        if (bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL len_zero_status: got %h expected %h", bus.readdata, 32'h0);
        end
        bus_write(3'd1, 32'd5);
        bus_write(3'd6, 32'h0);
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_read(3'd7);
        tests_run++;
        if (bus.readdata !== 32'h0 || out_port !== 8'h5A) begin
            tests_failed++;
            $display("FAIL mask_zero_and_ro: got status %h out %h expected %h / %h",
                     bus.readdata, out_port, 32'h0, 8'h5A);
        end
        bus_read(3'd4);
        tests_run++;
        if (bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL wo_reads_zero: got %h expected %h", bus.readdata, 32'h0);
        end
        bus_read(3'd1);
        tests_run++;
        if (bus.readdata !== 32'd5) begin
            tests_failed++;
            $display("FAIL pulse_len_read: got %h expected %h", bus.readdata, 32'd5);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bus_write(3'd1, 32'd10);
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h10);
        bus.address = 3'd7;
        @(posedge clk); #1;
        tests_run++;
        if (out_port !== 8'h10 || bus.readdata !== 32'h0000_1001) begin
            tests_failed++;
            $display("FAIL mid_pulse_pre: got out %h status %h expected %h / %h",
                     out_port, bus.readdata, 8'h10, 32'h0000_1001);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (out_port !== 8'hA5 || bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: got out %h rd %h expected %h / %h",
                     out_port, bus.readdata, 8'hA5, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(3'd7);
        tests_run++;
        if (bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_busy_clear: got %h expected %h", bus.readdata, 32'h0);
        end
        bus_read(3'd1);
        tests_run++;
        if (bus.readdata !== 32'd1000) begin
            tests_failed++;
            $display("FAIL reset_len_restore: got %0d expected %0d", bus.readdata, 1000);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        test_reset();
        test_data_set_clear();
        test_pulse();
        test_retrigger();
        test_expiry_priority();
        test_pulse_noop();
        test_reset_mid_pulse();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
